nn_cmd_sequencer: RTL and testbench

- Downstream consumer of the CPU-written 8-bit command PIO (`out_port`).
- Turns software command bytes into a valid/ready start handshake, an abort pulse and timeout supervision for the MNIST NN inference core.
- Returns an 8-bit status byte that a PIO input port can read back.
- The toggle bit makes every software write a single, level-independent command.

---
 rtl/nn_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_nn_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// nn_cmd_sequencer
//
// Converts software command bytes written through an 8-bit PIO into a
// valid/ready start handshake for the NN inference core. It also generates a
// one-cycle abort pulse and supervises each run with a timeout. A registered
// status byte is returned so the PIO input port can read it back.
//
// A command is accepted only when the toggle bit changes. This makes every
// software write act exactly once, regardless of how long the byte is held.
//
// Ports:
//   clk             system clock (single domain)
//   reset           synchronous, active-high reset
//   cmd_port[7:0]   {toggle, opcode[2:0], argument[3:0]}
//   nn_start_valid  start request to the NN core (registered)
//   nn_start_ready  NN core accepts the start request
//   nn_slot[3:0]    image slot for the request; held while nn_start_valid=1
//   nn_abort        one-cycle abort pulse to the NN core (registered)
//   nn_done         one-cycle inference-complete pulse
//   nn_result[3:0]  classified digit, valid with nn_done
//   status[7:0]     {busy, done, error, tog_echo, result[3:0]}
//
// Opcodes: 0 NOP, 1 START(slot=arg), 2 ABORT, 3 CLEAR, 4-7 illegal (error).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request outstanding; waits for START
// ST_ISSUE | nn_start_valid high; waits for nn_start_ready
// ST_RUN   | core running; waits for nn_done, ABORT or timeout
// ---------------------------------------------------------------------------
module nn_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_port,
  output logic       nn_start_valid,
  input  logic       nn_start_ready,
  output logic [3:0] nn_slot,
  output logic       nn_abort,
  input  logic       nn_done,
  input  logic [3:0] nn_result,
  output logic [7:0] status
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_ABORT = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;

  // The run times out on the edge where the counter reaches TIMEOUT_CYCLES-1.
  // The counter is cleared on the acceptance edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic             tog_q;
  logic             busy;
  logic             done;
  logic             error;
  logic [3:0]       result;
  logic [CNT_W-1:0] timeout_cnt;

  logic       cmd_new;
  logic [2:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       is_start;
  logic       is_abort;
  logic       is_clear;
  logic       is_illegal;

  // Level-independent command detect: any toggle change is exactly one command.
  assign cmd_new    = cmd_port[7] ^ tog_q;
  assign cmd_op     = cmd_port[6:4];
  assign cmd_arg    = cmd_port[3:0];
  assign is_start   = cmd_new && (cmd_op == OP_START);
  assign is_abort   = cmd_new && (cmd_op == OP_ABORT);
  assign is_clear   = cmd_new && (cmd_op == OP_CLEAR);
  assign is_illegal = cmd_new && cmd_op[2];

  // Every field is a flop, so the status byte is fully registered.
  assign status = {busy, done, error, tog_q, result};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      tog_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      result         <= 4'd0;
      nn_start_valid <= 1'b0;
      nn_slot        <= 4'd0;
      nn_abort       <= 1'b0;
      timeout_cnt    <= '0;
    end else begin
      nn_abort <= 1'b0;

      // The toggle is consumed even when the command is rejected or ignored.
      if (cmd_new) begin
        tog_q <= cmd_port[7];
      end

      if (is_illegal) begin
        error <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (is_start) begin
            nn_slot        <= cmd_arg;
            done           <= 1'b0;
            error          <= 1'b0;
            nn_start_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= ST_ISSUE;
          end else if (is_clear) begin
            done   <= 1'b0;
            error  <= 1'b0;
            result <= 4'd0;
          end
        end

        ST_ISSUE: begin
          if (is_start) begin
            error <= 1'b1;
          end
          if (is_clear) begin
            error  <= 1'b0;
            result <= 4'd0;
          end
          // If ready and ABORT arrive on the same edge, the handshake still
          // completes on that edge. The core then receives the abort pulse on
          // the next cycle, and the sequencer returns straight to idle.
          if (is_abort) begin
            nn_start_valid <= 1'b0;
            nn_abort       <= 1'b1;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end else if (nn_start_ready) begin
            nn_start_valid <= 1'b0;
            timeout_cnt    <= '0;
            state          <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (timeout_cnt != CNT_MAX) begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
          if (is_start) begin
            error <= 1'b1;
          end
          if (is_clear) begin
            error  <= 1'b0;
            result <= 4'd0;
          end
          // Priority on the same edge: nn_done, then ABORT, then timeout.
          // These later assignments override the command side effects above.
          if (nn_done) begin
            result <= nn_result;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (is_abort) begin
            nn_abort <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (timeout_cnt == CNT_LAST) begin
            nn_abort <= 1'b1;
            error    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          nn_start_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_cmd_sequencer.sv
module tb_nn_cmd_sequencer;

  localparam int unsigned T_CYC = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_port;
  logic       nn_start_valid;
  logic       nn_start_ready;
  logic [3:0] nn_slot;
  logic       nn_abort;
  logic       nn_done;
  logic [3:0] nn_result;
  logic [7:0] status;

  always #5 clk = ~clk;

  nn_cmd_sequencer #(.TIMEOUT_CYCLES(T_CYC), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_port       (cmd_port),
    .nn_start_valid (nn_start_valid),
    .nn_start_ready (nn_start_ready),
    .nn_slot        (nn_slot),
    .nn_abort       (nn_abort),
    .nn_done        (nn_done),
    .nn_result      (nn_result),
    .status         (status)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a request is either waiting for acceptance or running,
  // and the run's age is counted in edges since acceptance.
  bit         m_tog, m_waiting, m_running, m_valid, m_abort, m_done, m_err;
  logic [3:0] m_slot, m_res;
  int         m_age;

  function automatic logic [7:0] m_status();
    return {(m_waiting | m_running), m_done, m_err, m_tog, m_res};
  endfunction

  task automatic model_edge();
    bit         is_new;
    bit         abort_req;
    logic [2:0] op;
    logic [3:0] arg;
    if (reset) begin
      m_tog = 0; m_waiting = 0; m_running = 0; m_valid = 0; m_abort = 0;
      m_done = 0; m_err = 0; m_slot = 4'd0; m_res = 4'd0; m_age = 0;
      return;
    end
    is_new    = (cmd_port[7] != m_tog);
    op        = cmd_port[6:4];
    arg       = cmd_port[3:0];
    abort_req = is_new && (op == 3'd2);
    m_abort   = 0;
    if (is_new) m_tog = cmd_port[7];
    if (is_new && op >= 3'd4) m_err = 1;
    if (!m_waiting && !m_running) begin
      if (is_new && op == 3'd1) begin
        m_slot = arg; m_done = 0; m_err = 0; m_valid = 1; m_waiting = 1;
      end else if (is_new && op == 3'd3) begin
        m_done = 0; m_err = 0; m_res = 4'd0;
      end
    end else begin
      if (is_new && op == 3'd1) m_err = 1;
      if (is_new && op == 3'd3) begin m_err = 0; m_res = 4'd0; end
      if (m_waiting) begin
        if (abort_req) begin
          m_valid = 0; m_abort = 1; m_waiting = 0;
        end else if (nn_start_ready) begin
          m_valid = 0; m_waiting = 0; m_running = 1; m_age = 0;
        end
      end else begin
        m_age++;
        if (nn_done) begin
          m_res = nn_result; m_done = 1; m_running = 0;
        end else if (abort_req) begin
          m_abort = 1; m_running = 0;
        end else if (m_age >= int'(T_CYC)) begin
          m_abort = 1; m_err = 1; m_running = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("status", status, m_status());
    check("start_valid", {7'd0, nn_start_valid}, {7'd0, m_valid});
    check("slot", {4'd0, nn_slot}, {4'd0, m_slot});
    check("abort", {7'd0, nn_abort}, {7'd0, m_abort});
    check("valid_abort_excl", {7'd0, nn_start_valid & nn_abort}, 8'd0);
  endtask

  initial begin
    int         n_ab;
    int         ab_at;
    int         u;
    logic [2:0] op;

    reset = 1'b1; cmd_port = 8'h00; nn_start_ready = 1'b0;
    nn_done = 1'b0; nn_result = 4'd0;
    step(); step();
    check("reset_status", status, 8'h00);
    reset = 1'b0;

    // Steady command byte: nothing happens.
    for (int i = 0; i < 20; i++) step();
    check("idle_status", status, 8'h00);

    // START slot 3, stall the handshake, then accept and finish with digit 7.
    cmd_port = 8'h93;
    step();
    check("start_valid_now", {7'd0, nn_start_valid}, 8'd1);
    check("start_busy_tog", status & 8'h90, 8'h90);
    for (int i = 0; i < 5; i++) step();
    nn_start_ready = 1'b1;
    step();
    nn_start_ready = 1'b0;
    check("valid_dropped", {7'd0, nn_start_valid}, 8'd0);
    for (int i = 0; i < 9; i++) step();
    nn_done = 1'b1; nn_result = 4'd7;
    step();
    nn_done = 1'b0;
    check("done_status", status, 8'h57);

    // Timeout: accept a START and never complete it.
    cmd_port = 8'h13;
    step();
    nn_start_ready = 1'b1;
    step();
    nn_start_ready = 1'b0;
    n_ab = 0; ab_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (nn_abort) begin n_ab++; ab_at = i; end
    end
    check("timeout_pulses", 8'(n_ab), 8'd1);
    check("timeout_pos", 8'(ab_at), 8'(T_CYC));
    check("timeout_flags", status & 8'hA0, 8'h20);
    nn_done = 1'b1; nn_result = 4'd5;
    step();
    nn_done = 1'b0;
    check("late_done_result", {4'd0, status[3:0]}, 8'd7);

    // In RUN: rejected START, then ABORT together with nn_done.
    cmd_port = 8'h93;
    step();
    nn_start_ready = 1'b1;
    step();
    nn_start_ready = 1'b0;
    cmd_port = 8'h10;
    step();
    check("run_start_err", {7'd0, status[5]}, 8'd1);
    check("run_start_tog", {7'd0, status[4]}, 8'd0);
    cmd_port = 8'hA0; nn_done = 1'b1; nn_result = 4'd2;
    step();
    nn_done = 1'b0;
    check("done_beats_abort", {7'd0, nn_abort}, 8'd0);
    check("done_abort_status", status, 8'h72);
    step();
    check("no_late_abort", {7'd0, nn_abort}, 8'd0);

    // Illegal opcode, then CLEAR.
    cmd_port = 8'h70;
    step();
    check("illegal_status", status, 8'h62);
    cmd_port = 8'hB0;
    step();
    check("clear_status", status, 8'h10);

    // Reset while ISSUE is holding nn_start_valid.
    cmd_port = 8'h00;
    step();
    cmd_port = 8'h93;
    step();
    check("issue_valid", {7'd0, nn_start_valid}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid_status", status, 8'h00);
    check("reset_mid_valid", {7'd0, nn_start_valid}, 8'd0);
    check("reset_mid_abort", {7'd0, nn_abort}, 8'd0);
    step();
    check("retrigger_valid", {7'd0, nn_start_valid}, 8'd1);
    check("retrigger_slot", {4'd0, nn_slot}, 8'd3);
    nn_start_ready = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) begin
        u = int'($urandom_range(0, 9));
        if (u < 3)      op = 3'd1;
        else if (u < 5) op = 3'd2;
        else if (u < 7) op = 3'd3;
        else if (u < 8) op = 3'd0;
        else            op = 3'($urandom_range(4, 7));
        cmd_port = {~cmd_port[7], op, 4'($urandom_range(0, 15))};
      end else if ($urandom_range(0, 7) == 0) begin
        cmd_port[6:0] = 7'($urandom);
      end
      nn_start_ready = ($urandom_range(0, 2) == 0);
      nn_done        = ($urandom_range(0, 9) == 0);
      nn_result      = 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
